// File: rtl/larpix_event_pkg.sv
// -----------------------------------------------------------------------------
// larpix_event_pkg
// Shared definitions for the LArPix event path: the 64-bit packet field map,
// the data-packet type code, the timestamp width and the odd-parity helper
// used when EVENT_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package larpix_event_pkg;

    localparam logic [1:0] PKT_TYPE_DATA = 2'b01;
    localparam int         TS_W          = 31;

    // Packet field map (bit offsets within the 64-bit word).
    localparam int PKT_TYPE_LSB  = 0;
    localparam int CHIP_LSB      = 2;
    localparam int CHAN_LSB      = 10;
    localparam int CHAN_W        = 6;
    localparam int TS_LSB        = 16;
    localparam int ADC_LSB       = 48;
    localparam int ADC_W         = 8;
    localparam int TRIG_LSB      = 56;
    localparam int HALF_FULL_BIT = 61;
    localparam int FULL_SEEN_BIT = 62;
    localparam int PARITY_BIT    = 63;

    // Parity bit that gives the whole 64-bit packet an odd number of ones.
    function automatic logic odd_parity(input logic [62:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/event_router_if.sv
// -----------------------------------------------------------------------------
// event_router_if
// Bundles the channel-side handshake (ch_valid/ch_ready with ADC data and
// trigger type) and the lane-side dispatch bus (lane_enable/lane_ready/
// lane_valid/lane_data).
//   master : the environment (channels drive valid/data, serializers drive
//            enable/ready)
//   slave  : the event router
// -----------------------------------------------------------------------------
interface event_router_if #(
    parameter int NUMCHANNELS = 64,
    parameter int ADCBITS     = 8,
    parameter int WIDTH       = 64,
    parameter int NUM_TX      = 4
);
    logic [NUMCHANNELS-1:0]         ch_valid;
    logic [NUMCHANNELS*ADCBITS-1:0] ch_data;
    logic [2*NUMCHANNELS-1:0]       ch_trig_type;
    logic [NUMCHANNELS-1:0]         ch_ready;
    logic [NUM_TX-1:0]              lane_enable;
    logic [NUM_TX-1:0]              lane_ready;
    logic [NUM_TX-1:0]              lane_valid;
    logic [NUM_TX*WIDTH-1:0]        lane_data;

    modport master (
        output ch_valid, ch_data, ch_trig_type, lane_enable, lane_ready,
        input  ch_ready, lane_valid, lane_data
    );

    modport slave (
        input  ch_valid, ch_data, ch_trig_type, lane_enable, lane_ready,
        output ch_ready, lane_valid, lane_data
    );
endinterface

// File: rtl/event_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Single-clock synchronous FIFO without fall-through: an entry pushed on an
// edge is first visible on pop_data after that edge.
// Ports: clk, reset (sync, active high), push/push_data, pop/pop_data,
//        full, empty, count (occupancy, DEPTH representable).
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module event_fifo
    import larpix_event_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2048
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Qualify requests against occupancy and compute next pointers/count.
    always_comb begin
        do_push_s = push && (count_q != CW'(DEPTH));
        do_pop_s  = pop && (count_q != CW'(0));
        wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == CW'(0));
    assign count    = count_q;

endmodule

// File: rtl/event_router.sv
// -----------------------------------------------------------------------------
// event_router
// Round-robin collects ADC conversions from NUMCHANNELS channels, builds
// 64-bit data packets (chip ID, channel, timestamp, ADC word, trigger type,
// FIFO status), buffers them in a shared FIFO and dispatches one packet per
// cycle round-robin to the enabled output lanes.
// Ports: clk, reset (sync, active high), chip_id, timestamp_sync,
//        bus (event_router_if.slave: channel handshake + lane bus),
//        fifo_count, fifo_full_seen (sticky), clear_full_seen.
// Build option: EVENT_PARITY_EN - when defined, bit 63 carries odd parity
//        over bits 62:0; otherwise bit 63 is 0 and no parity logic exists.
// -----------------------------------------------------------------------------
module event_router
    import larpix_event_pkg::*;
#(
    parameter int NUMCHANNELS = 64,
    parameter int ADCBITS     = 8,
    parameter int WIDTH       = 64,
    parameter int NUM_TX      = 4,
    parameter int FIFO_DEPTH  = 2048,
    parameter int CHIP_ID_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHIP_ID_W-1:0]        chip_id,
    input  logic                        timestamp_sync,
    event_router_if.slave               bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_full_seen,
    input  logic                        clear_full_seen
);
    localparam int CH_W  = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1;
    localparam int LN_W  = (NUM_TX > 1) ? $clog2(NUM_TX) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [TS_W-1:0]         ts_q, ts_d;
    logic [CH_W-1:0]         last_grant_q, last_grant_d;
    logic [LN_W-1:0]         last_lane_q, last_lane_d;
    logic                    full_seen_q, full_seen_d;
    logic [NUM_TX-1:0]       lane_valid_q, lane_valid_d;
    logic [NUM_TX*WIDTH-1:0] lane_data_q, lane_data_d;

    logic                    grant_found_s, push_s, half_s;
    logic [CH_W-1:0]         grant_idx_s, ch_cand_s;
    logic [NUMCHANNELS-1:0]  ch_ready_s;
    logic [ADCBITS-1:0]      adc_s;
    logic [1:0]              trig_s;
    logic [WIDTH-1:0]        pkt_s;
    logic                    lane_found_s, pop_s;
    logic [LN_W-1:0]         lane_idx_s, lane_cand_s;
    logic                    fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]        fifo_count_s;
    logic [WIDTH-1:0]        fifo_dout_s;

    // Round-robin channel search starting just after the last granted channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        ch_cand_s     = '0;
        for (int i = 0; i < NUMCHANNELS; i++) begin
            ch_cand_s = CH_W'((int'(last_grant_q) + 1 + i) % NUMCHANNELS);
            if (!grant_found_s && bus.ch_valid[ch_cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ch_cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        // A grant is only offered while the FIFO can take it.
        push_s = grant_found_s && !fifo_full_s;
    end

    // One-hot ready plus data/trigger mux for the granted channel.
    always_comb begin
        ch_ready_s = '0;
        adc_s      = '0;
        trig_s     = 2'b00;
        for (int k = 0; k < NUMCHANNELS; k++) begin
            if (grant_idx_s == CH_W'(k)) begin
                ch_ready_s[k] = push_s;
                adc_s         = bus.ch_data[k*ADCBITS +: ADCBITS];
                trig_s        = bus.ch_trig_type[2*k +: 2];
            end else begin
                ch_ready_s[k] = 1'b0;
            end
        end
    end

    // Packet assembly for the push cycle.
    always_comb begin
        half_s = (fifo_count_s >= CNT_W'(FIFO_DEPTH / 2));
        pkt_s  = '0;
        pkt_s[PKT_TYPE_LSB +: 2]   = PKT_TYPE_DATA;
        pkt_s[CHIP_LSB +: 8]       = chip_id;
        pkt_s[CHAN_LSB +: CHAN_W]  = CHAN_W'(grant_idx_s);
        pkt_s[TS_LSB +: TS_W]      = ts_q;
        pkt_s[ADC_LSB +: ADC_W]    = ADC_W'(adc_s);
        pkt_s[TRIG_LSB +: 2]       = trig_s;
        pkt_s[HALF_FULL_BIT]       = half_s;
        pkt_s[FULL_SEEN_BIT]       = full_seen_q;
`ifdef EVENT_PARITY_EN
        pkt_s[PARITY_BIT]          = odd_parity(pkt_s[62:0]);
`else
        pkt_s[PARITY_BIT]          = 1'b0;
`endif
    end

    // Round-robin search for a free, enabled lane after the last loaded lane.
    always_comb begin
        lane_found_s = 1'b0;
        lane_idx_s   = '0;
        lane_cand_s  = '0;
        for (int j = 0; j < NUM_TX; j++) begin
            lane_cand_s = LN_W'((int'(last_lane_q) + 1 + j) % NUM_TX);
            if (!lane_found_s && bus.lane_enable[lane_cand_s] &&
                (!lane_valid_q[lane_cand_s] || bus.lane_ready[lane_cand_s])) begin
                lane_found_s = 1'b1;
                lane_idx_s   = lane_cand_s;
            end else begin
                lane_found_s = lane_found_s;
            end
        end
        pop_s = lane_found_s && !fifo_empty_s;
    end

    // Lane output registers: load on pop, otherwise empty once drained.
    always_comb begin
        lane_valid_d = lane_valid_q;
        lane_data_d  = lane_data_q;
        for (int j = 0; j < NUM_TX; j++) begin
            if (pop_s && (lane_idx_s == LN_W'(j))) begin
                lane_valid_d[j]                = 1'b1;
                lane_data_d[j*WIDTH +: WIDTH]  = fifo_dout_s;
            end else if (lane_valid_q[j] && bus.lane_ready[j]) begin
                lane_valid_d[j] = 1'b0;
            end else begin
                lane_valid_d[j] = lane_valid_q[j];
            end
        end
    end

    // Timestamp, arbitration pointers and the sticky full flag (set wins).
    always_comb begin
        ts_d         = timestamp_sync ? '0 : ts_q + 31'd1;
        last_grant_d = push_s ? grant_idx_s : last_grant_q;
        last_lane_d  = pop_s ? lane_idx_s : last_lane_q;
        if (fifo_full_s && (|bus.ch_valid)) begin
            full_seen_d = 1'b1;
        end else if (clear_full_seen) begin
            full_seen_d = 1'b0;
        end else begin
            full_seen_d = full_seen_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q         <= '0;
            last_grant_q <= '0;
            last_lane_q  <= '0;
            full_seen_q  <= 1'b0;
            lane_valid_q <= '0;
            lane_data_q  <= '0;
        end else begin
            ts_q         <= ts_d;
            last_grant_q <= last_grant_d;
            last_lane_q  <= last_lane_d;
            full_seen_q  <= full_seen_d;
            lane_valid_q <= lane_valid_d;
            lane_data_q  <= lane_data_d;
        end
    end

    event_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (pkt_s),
        .pop       (pop_s),
        .pop_data  (fifo_dout_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bus.ch_ready   = ch_ready_s;
    assign bus.lane_valid = lane_valid_q;
    assign bus.lane_data  = lane_data_q;
    assign fifo_count     = fifo_count_s;
    assign fifo_full_seen = full_seen_q;

endmodule

// File: tb/tb_event_router.sv
module tb_event_router;

    localparam int NCH   = 64;
    localparam int NT    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    chip_id;
    logic          timestamp_sync;
    logic [CW-1:0] fifo_count;
    logic          fifo_full_seen;
    logic          clear_full_seen;

    event_router_if #(.NUMCHANNELS(NCH), .ADCBITS(8), .WIDTH(64), .NUM_TX(NT)) bus ();

    event_router #(
        .NUMCHANNELS(NCH), .ADCBITS(8), .WIDTH(64), .NUM_TX(NT),
        .FIFO_DEPTH(DEPTH), .CHIP_ID_W(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .chip_id         (chip_id),
        .timestamp_sync  (timestamp_sync),
        .bus             (bus),
        .fifo_count      (fifo_count),
        .fifo_full_seen  (fifo_full_seen),
        .clear_full_seen (clear_full_seen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0]    m_q[$];
    int             m_last_grant = 0;
    int             m_last_lane  = 0;
    logic [NT-1:0]  m_lv = '0;
    logic [63:0]    m_ld[NT];
    logic           m_fs = 1'b0;
    longint         m_ts = 0;
    logic [NCH-1:0] obs_rdy;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_pkt(input int k, input logic [7:0] adc, input logic [1:0] trig,
                                           input logic [7:0] chip, input longint ts,
                                           input logic half, input logic fs);
        logic [63:0] p;
        p = 64'd1 | (64'(chip) << 2) | (64'(k) << 10) | (64'(ts) << 16) |
            (64'(adc) << 48) | (64'(trig) << 56) | (64'(half) << 61) | (64'(fs) << 62);
`ifdef EVENT_PARITY_EN
        if ($countones(p) % 2 == 0) p = p | (64'd1 << 63);
`endif
        return p;
    endfunction

    task automatic set_ch(input int k, input logic v, input logic [7:0] d, input logic [1:0] t);
        bus.ch_valid[k]          = v;
        bus.ch_data[k*8 +: 8]    = d;
        bus.ch_trig_type[k*2 +: 2] = t;
    endtask

    // One clock cycle: predict, check ch_ready, clock, check registered outputs.
    task automatic step();
        int g, l;
        logic full, half;
        logic [63:0] pkt;
        logic [NCH-1:0] exp_rdy;
        logic [NT*64-1:0] exp_ld;
        full = (m_q.size() == DEPTH);
        half = (m_q.size() >= DEPTH / 2);
        g = -1;
        if (!full) begin
            for (int i = 1; i <= NCH; i++) begin
                if (g < 0 && bus.ch_valid[(m_last_grant + i) % NCH]) g = (m_last_grant + i) % NCH;
            end
        end
        exp_rdy = '0;
        pkt = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            pkt = mk_pkt(g, bus.ch_data[g*8 +: 8], bus.ch_trig_type[g*2 +: 2], chip_id, m_ts, half, m_fs);
        end
        #1;
        obs_rdy = bus.ch_ready;
        check("ch_ready", 256'(bus.ch_ready), 256'(exp_rdy));
        l = -1;
        if (m_q.size() > 0) begin
            for (int i = 1; i <= NT; i++) begin
                int j;
                j = (m_last_lane + i) % NT;
                if (l < 0 && bus.lane_enable[j] && (!m_lv[j] || bus.lane_ready[j])) l = j;
            end
        end
        for (int j = 0; j < NT; j++) begin
            if (j == l) begin
                m_lv[j] = 1'b1;
                m_ld[j] = m_q[0];
            end else if (m_lv[j] && bus.lane_ready[j]) begin
                m_lv[j] = 1'b0;
            end
        end
        if (l >= 0) begin
            void'(m_q.pop_front());
            m_last_lane = l;
        end
        if (g >= 0) begin
            m_q.push_back(pkt);
            m_last_grant = g;
        end
        if (full && (|bus.ch_valid)) m_fs = 1'b1;
        else if (clear_full_seen) m_fs = 1'b0;
        m_ts = timestamp_sync ? 0 : ((m_ts + 1) & 64'h7FFF_FFFF);
        if (reset) begin
            m_q.delete();
            m_lv = '0;
            for (int j = 0; j < NT; j++) m_ld[j] = '0;
            m_fs = 1'b0;
            m_ts = 0;
            m_last_grant = 0;
            m_last_lane = 0;
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < NT; j++) exp_ld[j*64 +: 64] = m_ld[j];
        check("lane_valid", 256'(bus.lane_valid), 256'(m_lv));
        check("lane_data", 256'(bus.lane_data), 256'(exp_ld));
        check("fifo_count", 256'(fifo_count), 256'(m_q.size()));
        check("fifo_full_seen", 256'(fifo_full_seen), 256'(m_fs));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ch_valid = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] pkt;
        int ord[6] = '{3, 7, 60, 3, 7, 60};
        int lanes[$];
        logic [NT-1:0] seen;
        logic [63:0] got[$];

        for (int j = 0; j < NT; j++) m_ld[j] = '0;
        reset = 1'b1;
        chip_id = 8'h3C;
        timestamp_sync = 1'b0;
        clear_full_seen = 1'b0;
        bus.ch_valid = '0;
        bus.ch_data = '0;
        bus.ch_trig_type = '0;
        bus.lane_enable = '0;
        bus.lane_ready = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_lane_valid", 256'(bus.lane_valid), 256'(0));
        check("reset_fifo_count", 256'(fifo_count), 256'(0));

        // Single packet from channel 5 to lane 0, two edges from handshake.
        bus.lane_enable = 4'b0001;
        bus.lane_ready = 4'b1111;
        set_ch(5, 1'b1, 8'hA7, 2'b10);
        step();
        set_ch(5, 1'b0, 8'hA7, 2'b10);
        check("lat_edge1_invalid", 256'(bus.lane_valid), 256'(0));
        step();
        check("lat_edge2_valid", 256'(bus.lane_valid), 256'(4'b0001));
        pkt = bus.lane_data[63:0];
        check("pkt_type", 256'(pkt[1:0]), 256'(2'b01));
        check("pkt_chip", 256'(pkt[9:2]), 256'(8'h3C));
        check("pkt_chan", 256'(pkt[15:10]), 256'(5));
        check("pkt_adc", 256'(pkt[55:48]), 256'(8'hA7));
        check("pkt_trig", 256'(pkt[57:56]), 256'(2));
`ifdef EVENT_PARITY_EN
        check("pkt_odd_parity", 256'(^pkt), 256'(1));
`else
        check("pkt_parity_zero", 256'(pkt[63]), 256'(0));
`endif

        // Grant order among channels 3, 7, 60.
        do_reset();
        bus.lane_enable = 4'b1111;
        set_ch(3, 1'b1, 8'h13, 2'b01);
        set_ch(7, 1'b1, 8'h17, 2'b00);
        set_ch(60, 1'b1, 8'hF0, 2'b11);
        for (int i = 0; i < 6; i++) begin
            step();
            check("grant_order", 256'(obs_rdy), 256'(64'd1) << ord[i]);
        end
        bus.ch_valid = '0;
        repeat (3) step();

        // Lanes 1 and 3 only.
        do_reset();
        bus.lane_enable = 4'b1010;
        set_ch(9, 1'b1, 8'h99, 2'b01);
        seen = '0;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) bus.ch_valid = '0;
            step();
            seen = seen | bus.lane_valid;
            for (int j = 0; j < NT; j++) if (bus.lane_valid[j]) lanes.push_back(j);
        end
        check("lane_pkts", 256'(lanes.size()), 256'(6));
        for (int i = 0; i < lanes.size(); i++) check("lane_order", 256'(lanes[i]), 256'((i % 2 == 0) ? 1 : 3));
        check("lanes_0_2_idle", 256'(seen & 4'b0101), 256'(0));

        // Fill the 4-entry FIFO, sticky flag behaviour.
        do_reset();
        bus.lane_enable = 4'b0000;
        bus.lane_ready = 4'b0000;
        set_ch(10, 1'b1, 8'h5A, 2'b10);
        repeat (4) step();
        check("full_count", 256'(fifo_count), 256'(4));
        step();
        check("full_no_ready", 256'(obs_rdy), 256'(0));
        check("full_seen_set", 256'(fifo_full_seen), 256'(1));
        clear_full_seen = 1'b1;
        step();
        clear_full_seen = 1'b0;
        check("full_seen_set_wins", 256'(fifo_full_seen), 256'(1));
        bus.lane_enable = 4'b1111;
        bus.lane_ready = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            for (int j = 0; j < NT; j++) if (bus.lane_valid[j]) got.push_back(bus.lane_data[j*64 +: 64]);
        end
        bus.ch_valid = '0;
        repeat (6) step();
        check("drain_pkts", 256'(got.size() >= 5), 256'(1));
        check("pkt0_full_seen", 256'(got[0][62]), 256'(0));
        check("pkt4_full_seen", 256'(got[4][62]), 256'(1));
        check("pkt1_half", 256'(got[1][61]), 256'(0));
        check("pkt2_half", 256'(got[2][61]), 256'(1));

        // Timestamp sync: packet pushed 8 cycles after the pulse reads 7.
        do_reset();
        bus.lane_enable = 4'b0001;
        repeat (3) step();
        timestamp_sync = 1'b1;
        step();
        timestamp_sync = 1'b0;
        repeat (7) step();
        set_ch(20, 1'b1, 8'h20, 2'b00);
        step();
        bus.ch_valid = '0;
        step();
        check("ts_after_sync", 256'(bus.lane_data[46:16]), 256'(7));

        // Reset with FIFO contents and a held lane.
        do_reset();
        bus.lane_enable = 4'b0100;
        bus.lane_ready = 4'b0000;
        set_ch(11, 1'b1, 8'hB1, 2'b01);
        repeat (4) step();
        bus.ch_valid = '0;
        check("pre_reset_count", 256'(fifo_count), 256'(3));
        check("pre_reset_lane2", 256'(bus.lane_valid), 256'(4'b0100));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_count", 256'(fifo_count), 256'(0));
        check("mid_reset_lanes", 256'(bus.lane_valid), 256'(0));
        bus.lane_enable = 4'b1111;
        bus.lane_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_reset_idle", 256'(bus.lane_valid), 256'(0));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            bus.ch_valid = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            for (int w = 0; w < 16; w++) bus.ch_data[w*32 +: 32] = $urandom;
            for (int w = 0; w < 4; w++) bus.ch_trig_type[w*32 +: 32] = $urandom;
            bus.lane_enable = 4'($urandom);
            bus.lane_ready = 4'($urandom & $urandom);
            chip_id = 8'($urandom);
            clear_full_seen = ($urandom_range(0, 7) == 0);
            timestamp_sync = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
